// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX stage bundle: ID-side inputs (*_in, control bits, en/flush) and EX-side registered outputs.
// The master side drives the ID stage values; the slave side is the pipeline register.
interface id_ex_pipeline_reg_if #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  en;
    logic                  flush;
    logic                  valid_in;
    logic                  Branch;
    logic                  MemRead;
    logic                  MemtoReg;
    logic                  MemWrite;
    logic                  ALUSrc;
    logic                  RegWrite;
    logic [1:0]            ALUOp;
    logic [DATA_W-1:0]     PC_in;
    logic [DATA_W-1:0]     ReadData1_in;
    logic [DATA_W-1:0]     ReadData2_in;
    logic [DATA_W-1:0]     Imm_in;
    logic [3:0]            Funct_in;
    logic [REG_ADDR_W-1:0] rs1_in;
    logic [REG_ADDR_W-1:0] rs2_in;
    logic [REG_ADDR_W-1:0] rd_in;

    logic                  Branch_out;
    logic                  MemRead_out;
    logic                  MemtoReg_out;
    logic                  MemWrite_out;
    logic                  ALUSrc_out;
    logic                  RegWrite_out;
    logic [1:0]            ALUOp_out;
    logic [DATA_W-1:0]     PC_out;
    logic [DATA_W-1:0]     ReadData1_out;
    logic [DATA_W-1:0]     ReadData2_out;
    logic [DATA_W-1:0]     Imm_out;
    logic [3:0]            Funct_out;
    logic [REG_ADDR_W-1:0] rs1_out;
    logic [REG_ADDR_W-1:0] rs2_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic                  valid_out;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output en, flush, valid_in,
        output Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
        output PC_in, ReadData1_in, ReadData2_in, Imm_in, Funct_in,
        output rs1_in, rs2_in, rd_in,
        input  Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out, RegWrite_out,
        input  ALUOp_out, PC_out, ReadData1_out, ReadData2_out, Imm_out, Funct_out,
        input  rs1_out, rs2_out, rd_out, valid_out, bubble_cnt
    );

    modport slave (
        input  en, flush, valid_in,
        input  Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
        input  PC_in, ReadData1_in, ReadData2_in, Imm_in, Funct_in,
        input  rs1_in, rs2_in, rd_in,
        output Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out, RegWrite_out,
        output ALUOp_out, PC_out, ReadData1_out, ReadData2_out, Imm_out, Funct_out,
        output rs1_out, rs2_out, rd_out, valid_out, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with hold, flush-to-bubble and a saturating bubble counter.
// Interface parameters must match the module parameters of the instance.
module id_ex_pipeline_reg #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    id_ex_pipeline_reg_if.slave  bus
);

    logic             ctrl_zero;
    logic             bubble_load;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_q;

    // The stall multiplexer signals a bubble by zeroing every control bit.
    assign ctrl_zero = ~(bus.Branch | bus.MemRead | bus.MemtoReg | bus.MemWrite |
                         bus.ALUSrc | bus.RegWrite) && (bus.ALUOp == 2'b00);
    assign bubble_load = bus.flush | (bus.en & (~bus.valid_in | ctrl_zero));
    assign cnt_sat     = &cnt_q;

    // Flush clears data and indices too so rd_out = 0 never matches in forwarding.
    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            bus.Branch_out    <= 1'b0;
            bus.MemRead_out   <= 1'b0;
            bus.MemtoReg_out  <= 1'b0;
            bus.MemWrite_out  <= 1'b0;
            bus.ALUSrc_out    <= 1'b0;
            bus.RegWrite_out  <= 1'b0;
            bus.ALUOp_out     <= 2'b00;
            bus.PC_out        <= '0;
            bus.ReadData1_out <= '0;
            bus.ReadData2_out <= '0;
            bus.Imm_out       <= '0;
            bus.Funct_out     <= 4'b0000;
            bus.rs1_out       <= '0;
            bus.rs2_out       <= '0;
            bus.rd_out        <= '0;
            bus.valid_out     <= 1'b0;
        end else if (bus.en) begin
            bus.Branch_out    <= bus.Branch;
            bus.MemRead_out   <= bus.MemRead;
            bus.MemtoReg_out  <= bus.MemtoReg;
            bus.MemWrite_out  <= bus.MemWrite;
            bus.ALUSrc_out    <= bus.ALUSrc;
            bus.RegWrite_out  <= bus.RegWrite;
            bus.ALUOp_out     <= bus.ALUOp;
            bus.PC_out        <= bus.PC_in;
            bus.ReadData1_out <= bus.ReadData1_in;
            bus.ReadData2_out <= bus.ReadData2_in;
            bus.Imm_out       <= bus.Imm_in;
            bus.Funct_out     <= bus.Funct_in;
            bus.rs1_out       <= bus.rs1_in;
            bus.rs2_out       <= bus.rs2_in;
            bus.rd_out        <= bus.rd_in;
            bus.valid_out     <= bus.valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bubble_load && !cnt_sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: vector table, scoreboarded random traffic and a
// saturation run on a narrow-counter instance.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic [5:0]  ctrl;   // {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
        logic [1:0]  aluop;
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [3:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } stage_t;

    typedef enum logic [1:0] {E_ZERO, E_LOAD, E_HOLD} exp_e;

    typedef struct {
        logic   rst_n;
        logic   en;
        logic   flush;
        stage_t d;
        exp_e   kind;
        int     cnt;
    } vec_t;

    typedef struct {
        stage_t      st;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4;
    int   tests  = 0;
    int   failed = 0;

    exp_t       sb[$];
    logic [3:0] sb4[$];
    vec_t       tbl[$];

    always #5 clk = ~clk;

    id_ex_pipeline_reg_if #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(16)) bus ();
    id_ex_pipeline_reg_if #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4))  bus4 ();

    id_ex_pipeline_reg #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    id_ex_pipeline_reg #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4)
    );

    function automatic stage_t mk(input logic [5:0] c, input logic [1:0] op,
                                  input logic [63:0] pc, input logic [4:0] rd, input logic v);
        stage_t s;
        s.ctrl  = c;
        s.aluop = op;
        s.pc    = pc;
        s.rd1   = pc * 3 + 64'd1;
        s.rd2   = ~pc;
        s.imm   = {32'hFFFF_F000, pc[31:0]};
        s.funct = pc[3:0] ^ 4'hA;
        s.rs1   = rd + 5'd1;
        s.rs2   = rd ^ 5'h1F;
        s.rd    = rd;
        s.valid = v;
        return s;
    endfunction

    function automatic stage_t read_out();
        stage_t s;
        s.ctrl  = {bus.Branch_out, bus.MemRead_out, bus.MemtoReg_out,
                   bus.MemWrite_out, bus.ALUSrc_out, bus.RegWrite_out};
        s.aluop = bus.ALUOp_out;
        s.pc    = bus.PC_out;
        s.rd1   = bus.ReadData1_out;
        s.rd2   = bus.ReadData2_out;
        s.imm   = bus.Imm_out;
        s.funct = bus.Funct_out;
        s.rs1   = bus.rs1_out;
        s.rs2   = bus.rs2_out;
        s.rd    = bus.rd_out;
        s.valid = bus.valid_out;
        return s;
    endfunction

    task automatic drive(input logic r, input logic e, input logic f, input stage_t d);
        rst_n            = r;
        bus.en           = e;
        bus.flush        = f;
        bus.valid_in     = d.valid;
        {bus.Branch, bus.MemRead, bus.MemtoReg,
         bus.MemWrite, bus.ALUSrc, bus.RegWrite} = d.ctrl;
        bus.ALUOp        = d.aluop;
        bus.PC_in        = d.pc;
        bus.ReadData1_in = d.rd1;
        bus.ReadData2_in = d.rd2;
        bus.Imm_in       = d.imm;
        bus.Funct_in     = d.funct;
        bus.rs1_in       = d.rs1;
        bus.rs2_in       = d.rs2;
        bus.rd_in        = d.rd;
    endtask

    task automatic apply(input logic r, input logic e, input logic f, input stage_t d,
                         input stage_t es, input logic [15:0] ec, input string name);
        exp_t   x;
        stage_t got;
        drive(r, e, f, d);
        x.st = es; x.cnt = ec; x.name = name;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x   = sb.pop_front();
        got = read_out();
        tests++;
        if (got !== x.st) begin
            failed++;
            $display("FAIL %s outputs: got %h want %h", x.name, got, x.st);
        end
        tests++;
        if (bus.bubble_cnt !== x.cnt) begin
            failed++;
            $display("FAIL %s bubble_cnt: got %0d want %0d", x.name, bus.bubble_cnt, x.cnt);
        end
    endtask

    task automatic apply4(input logic e, input logic f, input logic v, input logic [3:0] ec);
        logic [3:0] w;
        rst4       = 1'b1;
        bus4.en    = e;
        bus4.flush = f;
        bus4.valid_in = v;
        sb4.push_back(ec);
        @(posedge clk);
        #1;
        w = sb4.pop_front();
        tests++;
        if (bus4.bubble_cnt !== w) begin
            failed++;
            $display("FAIL sat bubble_cnt: got %0d want %0d", bus4.bubble_cnt, w);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic f, input stage_t d,
                       input exp_e k, input int c);
        vec_t v;
        v.rst_n = r; v.en = e; v.flush = f; v.d = d; v.kind = k; v.cnt = c;
        tbl.push_back(v);
    endtask

    initial begin
        stage_t      prev;
        stage_t      es;
        stage_t      mst;
        stage_t      d;
        logic [15:0] mcnt;
        logic        r, e, f;

        // second instance sits in reset with quiet inputs until its own run
        rst4 = 1'b0;
        bus4.en = 1'b0; bus4.flush = 1'b0; bus4.valid_in = 1'b0;
        {bus4.Branch, bus4.MemRead, bus4.MemtoReg, bus4.MemWrite, bus4.ALUSrc, bus4.RegWrite} = '0;
        bus4.ALUOp = '0; bus4.PC_in = '0; bus4.ReadData1_in = '0; bus4.ReadData2_in = '0;
        bus4.Imm_in = '0; bus4.Funct_in = '0; bus4.rs1_in = '0; bus4.rs2_in = '0; bus4.rd_in = '0;

        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, '1, E_ZERO, 0);
        add(1'b1, 1'b1, 1'b0, mk(6'b000001, 2'b00, 64'h40, 5'd5, 1'b1), E_LOAD, 0);
        for (int i = 0; i < 4; i++)
            add(1'b1, 1'b0, 1'b0, mk(6'b111111, 2'b11, 64'h100 + i, 5'd9, 1'b1), E_HOLD, 0);
        add(1'b1, 1'b1, 1'b0, mk(6'b110000, 2'b01, 64'h200, 5'd6, 1'b1), E_LOAD, 0);
        add(1'b1, 1'b0, 1'b1, mk(6'b000100, 2'b00, 64'h300, 5'd7, 1'b1), E_ZERO, 1);
        add(1'b0, 1'b1, 1'b0, mk(6'b000001, 2'b00, 64'h380, 5'd2, 1'b1), E_ZERO, 0);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b1, 1'b0, mk(6'b000000, 2'b00, 64'h400 + 4 * i, 5'd3, 1'b1), E_LOAD, i + 1);
        add(1'b1, 1'b1, 1'b0, mk(6'b001010, 2'b10, 64'h500, 5'd8, 1'b1), E_LOAD, 3);
        add(1'b1, 1'b1, 1'b0, mk(6'b000001, 2'b00, 64'h504, 5'd9, 1'b0), E_LOAD, 4);
        add(1'b1, 1'b0, 1'b0, mk(6'b000000, 2'b00, 64'h0, 5'd0, 1'b0), E_HOLD, 4);
        add(1'b1, 1'b1, 1'b0, mk(6'b000000, 2'b10, 64'h508, 5'd10, 1'b1), E_LOAD, 4);
        add(1'b1, 1'b1, 1'b1, mk(6'b111111, 2'b11, 64'h50C, 5'd11, 1'b1), E_ZERO, 5);
        add(1'b1, 1'b1, 1'b0, mk(6'b100000, 2'b00, 64'h510, 5'd12, 1'b1), E_LOAD, 5);
        add(1'b0, 1'b1, 1'b1, mk(6'b010110, 2'b01, 64'h600, 5'd13, 1'b1), E_ZERO, 0);
        add(1'b1, 1'b1, 1'b0, mk(6'b000001, 2'b00, 64'h604, 5'd14, 1'b1), E_LOAD, 0);

        prev = '0;
        foreach (tbl[i]) begin
            case (tbl[i].kind)
                E_ZERO:  es = '0;
                E_LOAD:  es = tbl[i].d;
                default: es = prev;
            endcase
            apply(tbl[i].rst_n, tbl[i].en, tbl[i].flush, tbl[i].d, es,
                  16'(tbl[i].cnt), $sformatf("vec%0d", i));
            prev = es;
        end

        // random traffic against a behavioural model; state follows the last vector
        mst  = prev;
        mcnt = 16'd0;
        for (int i = 0; i < 60; i++) begin
            r = ($urandom_range(0, 19) != 0);
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 5) == 0);
            d = mk(6'($urandom_range(0, 3) == 0 ? 0 : $urandom), 2'($urandom),
                   {$urandom, $urandom}, 5'($urandom), 1'($urandom_range(0, 4) != 0));
            if (!r) begin
                mst = '0; mcnt = '0;
            end else if (f) begin
                mst = '0;
                if (mcnt != 16'hFFFF) mcnt++;
            end else if (e) begin
                mst = d;
                if ((!d.valid || (d.ctrl == 6'd0 && d.aluop == 2'd0)) && mcnt != 16'hFFFF) mcnt++;
            end
            apply(r, e, f, d, mst, mcnt, $sformatf("rnd%0d", i));
        end

        // narrow counter: clear, then 20 bubbles must stop at 15
        rst4 = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++)
            apply4(1'($urandom), 1'b1, 1'b1, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
        for (int i = 0; i < 3; i++) apply4(1'b0, 1'b0, 1'b0, 4'd15);
        apply4(1'b1, 1'b0, 1'b0, 4'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register for the 5-stage RV64 pipelined processor.
- Sits directly downstream of the ID-stage stall multiplexer. It captures the (possibly bubbled) control bits, register-file read data, immediate, PC and register indices, and presents them to the EX stage, forwarding unit and hazard unit one cycle later.
- Supports hold (stall), flush (taken branch) and a saturating bubble counter for performance debug.

Parameters:
DATA_W, 64, width of PC, register read data and immediate
REG_ADDR_W, 5, width of register indices
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
en  input  1  load enable; 0 = hold current contents
flush  input  1  1 = load a bubble (branch taken in MEM)
valid_in  input  1  ID stage holds a real instruction
Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  input  1 each  control bits from stall multiplexer
ALUOp  input  2  ALU operation class from stall multiplexer
PC_in  input  DATA_W  PC of ID instruction
ReadData1_in, ReadData2_in  input  DATA_W  register file read ports
Imm_in  input  DATA_W  sign-extended immediate
Funct_in  input  4  {instr[30], instr[14:12]}
rs1_in, rs2_in, rd_in  input  REG_ADDR_W  register indices
Branch_out, MemRead_out, MemtoReg_out, MemWrite_out, ALUSrc_out, RegWrite_out  output  1 each  registered control
ALUOp_out  output  2  registered ALUOp
PC_out, ReadData1_out, ReadData2_out, Imm_out  output  DATA_W  registered data
Funct_out  output  4  registered funct
rs1_out, rs2_out, rd_out  output  REG_ADDR_W  registered indices
valid_out  output  1  EX stage holds a real instruction
bubble_cnt  output  CNT_W  count of bubbles loaded since reset

Behaviour:
- All outputs are registers; 1-cycle latency input to output; no combinational paths.
- Priority at each rising clk edge: reset low > flush > en low > normal load.
- reset low: every output cleared to 0, including bubble_cnt and valid_out; takes effect regardless of en/flush. Reset mid-stream discards the held instruction.
- flush high (any en): all control outputs, ALUOp_out and valid_out set to 0. All data/index outputs also cleared to 0, so rd_out = 0 and the forwarding unit never matches. Flush overrides hold.
- en low, flush low: every output, including bubble_cnt, keeps its value.
- Normal load (en high, flush low): each *_out takes its *_in. valid_out takes valid_in.
- Bubble definition: a load cycle in which flush = 1, or valid_in = 0, or all six control inputs and ALUOp are 0 (the stall multiplexer's bubble).
- bubble_cnt increments by 1 on every bubble load. It saturates at 2^CNT_W-1 and does not wrap. It is not incremented during hold cycles.
- No X propagation: all regs have defined reset values. Inputs sampled only at the clock edge.

Test Plan:
1. Hold reset low 3 cycles with all inputs 1s -> every output 0, bubble_cnt = 0. Release reset, load PC_in = 0x40, RegWrite = 1, rd_in = 5, valid_in = 1 -> next cycle PC_out = 0x40, RegWrite_out = 1, rd_out = 5, valid_out = 1, bubble_cnt = 0.
2. Loaded state, then en = 0 for 4 cycles while inputs change -> all outputs unchanged, bubble_cnt unchanged. Then en = 1 -> new inputs appear 1 cycle later.
3. flush = 1 with en = 0 and MemWrite = 1, rd_in = 7 -> next cycle all outputs 0, valid_out = 0, bubble_cnt increments by 1.
4. Stall-multiplexer bubble (all control 0, valid_in = 1) loaded 3 cycles -> control outputs 0, bubble_cnt = 3. Real instruction next -> bubble_cnt stays 3.
5. Preload bubble_cnt near saturation (CNT_W = 4 override), issue 20 bubbles -> bubble_cnt stops at 15.
6. Assert reset low in the same cycle as flush = 1 and en = 1 with nonzero inputs -> all outputs 0 next cycle, bubble_cnt = 0 (reset wins).
